// File: rtl/neuron_mac_q55_if.sv
// Handshake bundle between a neuron_mac_q55 stage and its producer/consumer.
// slave is the MAC's view; master is the driver/consumer view.
interface neuron_mac_q55_if #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 9,
  parameter int OUT_WIDTH  = 10
);
  logic                  start;
  logic [LEN_WIDTH-1:0]  len;
  logic [DATA_WIDTH-1:0] bias;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] x_in;
  logic [DATA_WIDTH-1:0] w_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_WIDTH-1:0]  z_out;
  logic                  sat_flag;
  logic                  busy;

  modport slave (
    input  start, len, bias, in_valid, x_in, w_in, out_ready,
    output in_ready, out_valid, z_out, sat_flag, busy
  );

  modport master (
    output start, len, bias, in_valid, x_in, w_in, out_ready,
    input  in_ready, out_valid, z_out, sat_flag, busy
  );
endinterface

// File: rtl/neuron_mac_q55.sv
// Q8.8 multiply-accumulate producing a saturated Q5.5 neuron pre-activation.
// Define NEURON_MAC_ROUND_EN for round-half-up requantisation (default truncates).
module neuron_mac_q55 #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 8,
  parameter int ACC_WIDTH   = 40,
  parameter int LEN_WIDTH   = 9,
  parameter int OUT_WIDTH   = 10,
  parameter int OUT_FRAC    = 5
) (
  input logic clk,
  input logic reset,
  neuron_mac_q55_if.slave bus
);
  localparam int SHIFT = 2*FRACT_WIDTH - OUT_FRAC;
  localparam logic signed [ACC_WIDTH-1:0] Z_MAX = ACC_WIDTH'(2**(OUT_WIDTH-1) - 1);
  localparam logic signed [ACC_WIDTH-1:0] Z_MIN = ~Z_MAX;

  typedef enum logic [1:0] {IDLE, ACCUM, FIN, DONE} state_t;

  state_t                      state, state_nxt;
  logic signed [ACC_WIDTH-1:0] acc, acc_nxt;
  logic [LEN_WIDTH-1:0]        cnt, cnt_nxt;
  logic [OUT_WIDTH-1:0]        z_q;
  logic                        sat_q;

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    prod_ext, bias_aligned;
  logic signed [ACC_WIDTH-1:0]    acc_r, r_full;
  logic [OUT_WIDTH-1:0]           r_clip;
  logic                           r_sat;

  assign prod         = $signed(bus.x_in) * $signed(bus.w_in);
  assign prod_ext     = $signed({{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod});
  assign bias_aligned = $signed({{(ACC_WIDTH-DATA_WIDTH){bus.bias[DATA_WIDTH-1]}}, bus.bias})
                        <<< FRACT_WIDTH;

`ifdef NEURON_MAC_ROUND_EN
  localparam logic signed [ACC_WIDTH-1:0] ROUND_HALF = ACC_WIDTH'(1) <<< (SHIFT-1);
  assign acc_r = acc + ROUND_HALF;
`else
  assign acc_r = acc;
`endif

  // Sum cannot overflow ACC_WIDTH for any legal len, so only the output needs clipping.
  always_comb begin
    r_full = acc_r >>> SHIFT;
    r_sat  = 1'b0;
    r_clip = r_full[OUT_WIDTH-1:0];
    if (r_full > Z_MAX) begin
      r_sat  = 1'b1;
      r_clip = Z_MAX[OUT_WIDTH-1:0];
    end else if (r_full < Z_MIN) begin
      r_sat  = 1'b1;
      r_clip = Z_MIN[OUT_WIDTH-1:0];
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (bus.start) begin
        acc_nxt   = bias_aligned;
        cnt_nxt   = bus.len;
        state_nxt = (bus.len != '0) ? ACCUM : FIN;
      end
      ACCUM: if (bus.in_valid) begin
        acc_nxt = acc + prod_ext;
        cnt_nxt = cnt - LEN_WIDTH'(1);
        if (cnt == LEN_WIDTH'(1)) state_nxt = FIN;
      end
      FIN:  state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      z_q   <= '0;
      sat_q <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      if (state == FIN) begin
        z_q   <= r_clip;
        sat_q <= r_sat;
      end
    end
  end

  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.z_out     = z_q;
  assign bus.sat_flag  = sat_q;
endmodule
